// File: rtl/reg_write_back.sv
// rtl/reg_write_back.sv - write-back buffer queuing register-file writes with forwarding lookup
// Selects result source, drops $0/non-writing beats, holds pending writes until rfAccept.
module reg_write_back #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inValid,
  output logic          inReady,
  input  logic          inRegWrite,
  input  logic          inMemToReg,
  input  logic          inLink,
  input  logic [4:0]    inDest,
  input  logic [31:0]   aluResult,
  input  logic [31:0]   memData,
  input  logic [31:0]   pc,
  output logic          regWrite,
  output logic [4:0]    writeRegister,
  output logic [31:0]   writeData,
  input  logic          rfAccept,
  input  logic [4:0]    lookupReg1,
  input  logic [4:0]    lookupReg2,
  output logic          hit1,
  output logic          hit2,
  output logic [31:0]   fwdData1,
  output logic [31:0]   fwdData2,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [4:0]    sel_dest;
  logic [31:0]   sel_data;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign inReady = !full;
  assign count   = cnt;

  assign sel_dest = inLink ? 5'd31 : inDest;
  assign sel_data = inLink ? (pc + 32'd4) : (inMemToReg ? memData : aluResult);

  // Link beats always land on r31, so only non-link beats can be discarded.
  assign accept = inValid && inReady;
  assign push   = accept && (inLink || (inRegWrite && (sel_dest != 5'd0)));
  assign pop    = !empty && rfAccept;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      dest_mem[wr_ptr] <= sel_dest;
      data_mem[wr_ptr] <= sel_data;
    end
  end

  assign regWrite      = !empty;
  assign writeRegister = empty ? 5'd0  : dest_mem[rd_ptr];
  assign writeData     = empty ? 32'd0 : data_mem[rd_ptr];

  // Walk oldest to newest so the newest match is the one left standing.
  always_comb begin
    logic [AW-1:0] fidx;
    hit1     = 1'b0;
    hit2     = 1'b0;
    fwdData1 = 32'd0;
    fwdData2 = 32'd0;
    fidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr + AW'(k);
      if (CW'(k) < cnt) begin
        if ((lookupReg1 != 5'd0) && (dest_mem[fidx] == lookupReg1)) begin
          hit1     = 1'b1;
          fwdData1 = data_mem[fidx];
        end
        if ((lookupReg2 != 5'd0) && (dest_mem[fidx] == lookupReg2)) begin
          hit2     = 1'b1;
          fwdData2 = data_mem[fidx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_back.sv
// tb/tb_reg_write_back.sv - scoreboard bench for reg_write_back
// Stimulus queues expected writes; a negedge monitor checks each popped head.
module tb_reg_write_back;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady, inRegWrite, inMemToReg, inLink;
  logic [4:0]  inDest;
  logic [31:0] aluResult, memData, pc;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        rfAccept;
  logic [4:0]  lookupReg1, lookupReg2;
  logic        hit1, hit2;
  logic [31:0] fwdData1, fwdData2;
  logic [2:0]  count;

  int passes = 0;
  int checks = 0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  reg_write_back #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .inLink(inLink),
    .inDest(inDest), .aluResult(aluResult), .memData(memData), .pc(pc),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .rfAccept(rfAccept), .lookupReg1(lookupReg1), .lookupReg2(lookupReg2),
    .hit1(hit1), .hit2(hit2), .fwdData1(fwdData1), .fwdData2(fwdData2),
    .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic rw, input logic m2r, input logic lnk, input logic [4:0] dst,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] p);
    inValid = 1'b1; inRegWrite = rw; inMemToReg = m2r; inLink = lnk;
    inDest = dst; aluResult = alu; memData = mem; pc = p;
  endtask

  task automatic idle();
    inValid = 1'b0; inRegWrite = 1'b0; inMemToReg = 1'b0; inLink = 1'b0;
    inDest = 5'd0; aluResult = 32'd0; memData = 32'd0; pc = 32'd0;
  endtask

  // Monitor: a head write that will be consumed at the next edge must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && regWrite && rfAccept) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got reg %0d data 0x%08h expected none", writeRegister, writeData);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("pop_reg", {27'd0, writeRegister}, {27'd0, e[36:32]});
        chk("pop_data", writeData, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; rfAccept = 1'b0; lookupReg1 = 5'd5; lookupReg2 = 5'd0;
    idle();
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_writeRegister", {27'd0, writeRegister}, 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_inReady", {31'd0, inReady}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_hit1", {31'd0, hit1}, 32'd0);

    // Basic ALU write with 1-cycle latency
    rfAccept = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_00AA, 32'h0, 32'h0);
    exp_q.push_back({5'd5, 32'h0000_00AA});
    cyc(); idle();
    chk("t1_regWrite", {31'd0, regWrite}, 32'd1);
    chk("t1_writeRegister", {27'd0, writeRegister}, 32'd5);
    chk("t1_writeData", writeData, 32'h0000_00AA);
    cyc();
    chk("t1_regWrite_after", {31'd0, regWrite}, 32'd0);
    chk("t1_count_after", {29'd0, count}, 32'd0);

    // Link wraps pc+4 and overrides memToReg / inDest
    beat(1'b0, 1'b1, 1'b1, 5'd7, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFC);
    exp_q.push_back({5'd31, 32'h0000_0000});
    cyc(); idle();
    chk("link_reg", {27'd0, writeRegister}, 32'd31);
    chk("link_data", writeData, 32'h0);
    cyc();
    beat(1'b1, 1'b1, 1'b0, 5'd8, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0);
    exp_q.push_back({5'd8, 32'hDEAD_BEEF});
    cyc(); idle();
    chk("mem_data", writeData, 32'hDEAD_BEEF);
    cyc();

    // Discards
    rfAccept = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 32'h0, 32'h0);
    cyc();
    beat(1'b0, 1'b0, 1'b0, 5'd9, 32'h66, 32'h0, 32'h0);
    cyc(); idle();
    chk("discard_count", {29'd0, count}, 32'd0);
    chk("discard_regWrite", {31'd0, regWrite}, 32'd0);

    // Backpressure: 5 beats, 4 fit
    for (int i = 1; i <= 5; i++) begin
      beat(1'b1, 1'b0, 1'b0, 5'(i), 32'(i * 16), 32'h0, 32'h0);
      if (i <= 4) exp_q.push_back({5'(i), 32'(i * 16)});
      else begin
        chk("bp_inReady_full", {31'd0, inReady}, 32'd0);
        chk("bp_count_full", {29'd0, count}, 32'd4);
      end
      cyc();
    end
    idle();
    chk("bp_count_hold", {29'd0, count}, 32'd4);
    chk("bp_head_reg", {27'd0, writeRegister}, 32'd1);
    rfAccept = 1'b1;
    chk("bp_inReady_no_comb", {31'd0, inReady}, 32'd0);
    cyc();
    chk("bp_inReady_back", {31'd0, inReady}, 32'd1);
    chk("bp_count_3", {29'd0, count}, 32'd3);
    cyc(); cyc(); cyc();
    chk("bp_drained", {29'd0, count}, 32'd0);

    // Forwarding picks newest of duplicate entries
    rfAccept = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 5'd3, 32'h11, 32'h0, 32'h0);
    exp_q.push_back({5'd3, 32'h11});
    cyc();
    beat(1'b1, 1'b0, 1'b0, 5'd3, 32'h22, 32'h0, 32'h0);
    exp_q.push_back({5'd3, 32'h22});
    cyc(); idle();
    lookupReg1 = 5'd3; lookupReg2 = 5'd0;
    #1;
    chk("fwd_hit1", {31'd0, hit1}, 32'd1);
    chk("fwd_data1", fwdData1, 32'h22);
    chk("fwd_hit2_zero", {31'd0, hit2}, 32'd0);
    chk("fwd_data2_zero", fwdData2, 32'h0);
    lookupReg2 = 5'd4;
    #1;
    chk("fwd_hit2_miss", {31'd0, hit2}, 32'd0);
    rfAccept = 1'b1;
    cyc();
    chk("fwd_after_pop", fwdData1, 32'h22);
    cyc(); cyc();
    chk("fwd_empty_hit1", {31'd0, hit1}, 32'd0);

    // Back-to-back throughput with rfAccept held
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0, 1'b0, 5'(20 + i), 32'h100 + 32'(i), 32'h0, 32'h0);
      exp_q.push_back({5'(20 + i), 32'h100 + 32'(i)});
      cyc();
      chk("tput_count", {29'd0, count}, 32'd1);
    end
    idle();
    cyc();

    // Reset mid-queue drops pending entries
    rfAccept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0, 1'b0, 5'(10 + i), 32'hA0 + 32'(i), 32'h0, 32'h0);
      cyc();
    end
    idle();
    chk("mid_count_3", {29'd0, count}, 32'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    lookupReg1 = 5'd10; lookupReg2 = 5'd11;
    #1;
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("mid_rst_hit1", {31'd0, hit1}, 32'd0);
    chk("mid_rst_hit2", {31'd0, hit2}, 32'd0);
    rfAccept = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 5'd13, 32'hC3, 32'h0, 32'h0);
    exp_q.push_back({5'd13, 32'hC3});
    cyc(); idle();
    chk("post_rst_reg", {27'd0, writeRegister}, 32'd13);
    cyc(); cyc();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
